// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline with valid/ready handshake on both sides.
// Stage 1 registers the operands; stage 2 computes and registers result and flags.
module alu_pipe #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_OP-1:0]   i_op,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_zero,
    output logic               o_negative,
    output logic               o_carry,
    output logic               o_overflow,
    output logic               o_err
);

    localparam int MSB = NB_DATA - 1;

    localparam logic [NB_OP-1:0] OP_ADD  = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB  = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND  = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR   = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR  = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR  = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRL  = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_SRA  = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SLL  = NB_OP'(6'b000000);
    localparam logic [NB_OP-1:0] OP_SLT  = NB_OP'(6'b101010);
    localparam logic [NB_OP-1:0] OP_SLTU = NB_OP'(6'b101011);

    logic               s1_valid_reg, s1_valid_next;
    logic [NB_DATA-1:0] s1_a_reg, s1_b_reg;
    logic [NB_OP-1:0]   s1_op_reg;

    logic               out_valid_reg;
    logic [NB_DATA-1:0] result_reg, result_next;
    logic               zero_reg, zero_next;
    logic               neg_reg, neg_next;
    logic               carry_reg, carry_next;
    logic               ovf_reg, ovf_next;
    logic               err_reg, err_next;

    logic s2_ready;
    logic up_xfer;

    // Ready depends only on registered valids, never on i_valid.
    assign s2_ready = !out_valid_reg || i_ready;
    assign o_ready  = !s1_valid_reg || s2_ready;
    assign up_xfer  = i_valid && o_ready;

    always_comb begin
        s1_valid_next = s1_valid_reg;
        if (up_xfer)
            s1_valid_next = 1'b1;
        else if (s2_ready)
            s1_valid_next = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_op_reg    <= '0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            if (up_xfer) begin
                s1_a_reg  <= i_data_a;
                s1_b_reg  <= i_data_b;
                s1_op_reg <= i_op;
            end
        end
    end

    logic [NB_DATA:0]   add_full, sub_full;
    logic [NB_DATA-1:0] and_bits, or_bits, xor_bits, nor_bits;
    logic [NB_DATA-1:0] srl_val, sra_val, sll_val;
    logic               slt_bit, sltu_bit;

    assign add_full = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
    assign sub_full = {1'b0, s1_a_reg} - {1'b0, s1_b_reg};

    generate
        for (genvar gi = 0; gi < NB_DATA; gi++) begin : g_logic
            assign and_bits[gi] = s1_a_reg[gi] & s1_b_reg[gi];
            assign or_bits[gi]  = s1_a_reg[gi] | s1_b_reg[gi];
            assign xor_bits[gi] = s1_a_reg[gi] ^ s1_b_reg[gi];
            assign nor_bits[gi] = ~(s1_a_reg[gi] | s1_b_reg[gi]);
        end
    endgenerate

    // The whole of B is the shift amount; amounts >= NB_DATA shift everything out
    // (zero fill, or sign fill for the arithmetic shift).
    assign srl_val  = s1_a_reg >> s1_b_reg;
    assign sll_val  = s1_a_reg << s1_b_reg;
    assign sra_val  = $signed(s1_a_reg) >>> s1_b_reg;
    assign slt_bit  = $signed(s1_a_reg) < $signed(s1_b_reg);
    assign sltu_bit = s1_a_reg < s1_b_reg;

    always_comb begin
        result_next = '0;
        carry_next  = 1'b0;
        ovf_next    = 1'b0;
        err_next    = 1'b0;
        case (s1_op_reg)
            OP_ADD: begin
                result_next = add_full[MSB:0];
                carry_next  = add_full[NB_DATA];
                ovf_next    = (s1_a_reg[MSB] == s1_b_reg[MSB]) && (add_full[MSB] != s1_a_reg[MSB]);
            end
            OP_SUB: begin
                result_next = sub_full[MSB:0];
                carry_next  = sub_full[NB_DATA];
                ovf_next    = (s1_a_reg[MSB] != s1_b_reg[MSB]) && (sub_full[MSB] != s1_a_reg[MSB]);
            end
            OP_AND:  result_next = and_bits;
            OP_OR:   result_next = or_bits;
            OP_XOR:  result_next = xor_bits;
            OP_NOR:  result_next = nor_bits;
            OP_SRL:  result_next = srl_val;
            OP_SRA:  result_next = sra_val;
            OP_SLL:  result_next = sll_val;
            OP_SLT:  result_next = {{(NB_DATA-1){1'b0}}, slt_bit};
            OP_SLTU: result_next = {{(NB_DATA-1){1'b0}}, sltu_bit};
            default: err_next = 1'b1;
        endcase
        zero_next = (result_next == '0);
        neg_next  = result_next[MSB];
    end

    // Output stage only moves when downstream can take it, so a stalled result holds.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            neg_reg       <= 1'b0;
            carry_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else if (s2_ready) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                result_reg <= result_next;
                zero_reg   <= zero_next;
                neg_reg    <= neg_next;
                carry_reg  <= carry_next;
                ovf_reg    <= ovf_next;
                err_reg    <= err_next;
            end
        end
    end

    assign o_valid    = out_valid_reg;
    assign o_result   = result_reg;
    assign o_zero     = zero_reg;
    assign o_negative = neg_reg;
    assign o_carry    = carry_reg;
    assign o_overflow = ovf_reg;
    assign o_err      = err_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboarded bench for alu_pipe: arithmetic reference model, directed vectors,
// backpressure and reset scenarios, then randomized traffic with random i_ready.
module tb_alu_pipe;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;

    localparam logic [5:0] ADD  = 6'b100000;
    localparam logic [5:0] SUB  = 6'b100010;
    localparam logic [5:0] AND_ = 6'b100100;
    localparam logic [5:0] OR_  = 6'b100101;
    localparam logic [5:0] XOR_ = 6'b100110;
    localparam logic [5:0] NOR_ = 6'b100111;
    localparam logic [5:0] SRL  = 6'b000010;
    localparam logic [5:0] SRA  = 6'b000011;
    localparam logic [5:0] SLL  = 6'b000000;
    localparam logic [5:0] SLT  = 6'b101010;
    localparam logic [5:0] SLTU = 6'b101011;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_valid = 1'b0;
    logic [7:0] i_data_a = '0;
    logic [7:0] i_data_b = '0;
    logic [5:0] i_op = '0;
    logic       i_ready;
    logic       o_ready, o_valid;
    logic [7:0] o_result;
    logic       o_zero, o_negative, o_carry, o_overflow, o_err;

    logic rand_mode = 1'b0;
    logic rdy_force = 1'b1;
    logic rdy_rand  = 1'b1;
    assign i_ready = rand_mode ? rdy_rand : rdy_force;

    alu_pipe #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_data_a(i_data_a), .i_data_b(i_data_b), .i_op(i_op),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
        .o_zero(o_zero), .o_negative(o_negative), .o_carry(o_carry),
        .o_overflow(o_overflow), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        #1;
        rdy_rand = ($urandom_range(0, 3) != 0);
    end

    typedef struct packed {
        logic [7:0] r;
        logic z, n, c, v, e;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   txn = 0;

    // Reference model: plain integer arithmetic on the 8-bit operands.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        exp_t e;
        int ua, ub, sa, sb, r, s;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        e = '0;
        r = 0;
        case (op)
            ADD: begin
                r = (ua + ub) % 256;
                e.c = (ua + ub) > 255;
                s = sa + sb;
                e.v = (s > 127) || (s < -128);
            end
            SUB: begin
                r = (ua - ub + 256) % 256;
                e.c = ua < ub;
                s = sa - sb;
                e.v = (s > 127) || (s < -128);
            end
            AND_: r = ua & ub;
            OR_:  r = ua | ub;
            XOR_: r = ua ^ ub;
            NOR_: r = (~(ua | ub)) & 255;
            SRL:  r = (ub >= 8) ? 0 : (ua >> ub);
            SLL:  r = (ub >= 8) ? 0 : ((ua << ub) & 255);
            SRA:  r = (ub >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> ub) & 255);
            SLT:  r = (sa < sb) ? 1 : 0;
            SLTU: r = (ua < ub) ? 1 : 0;
            default: e.e = 1'b1;
        endcase
        e.r = 8'(r);
        e.z = (r == 0);
        e.n = (r >= 128);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the head of the scoreboard,
    // pop on a downstream transfer, and push a model result on every upstream transfer.
    always @(negedge i_clk) begin
        if (!i_reset && o_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got result 0x%02h expected no output", o_result);
            end else begin
                mon_e = sb_q[0];
                chk("result_flags", 32'({o_result, o_zero, o_negative, o_carry, o_overflow, o_err}),
                    32'(mon_e));
                if (i_ready) begin
                    void'(sb_q.pop_front());
                    $display("txn %0d: result=0x%02h z=%0b n=%0b c=%0b v=%0b err=%0b",
                             txn, o_result, o_zero, o_negative, o_carry, o_overflow, o_err);
                    txn++;
                end
            end
        end
        if (!i_reset && i_valid && o_ready)
            sb_q.push_back(model(i_data_a, i_data_b, i_op));
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        bit accepted;
        accepted = 1'b0;
        i_data_a = a;
        i_data_b = b;
        i_op     = op;
        i_valid  = 1'b1;
        for (int t = 0; t < 200 && !accepted; t++) begin
            @(negedge i_clk);
            accepted = o_ready;
            @(posedge i_clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got o_ready=0 for 200 cycles expected acceptance");
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge i_clk);
            done = (sb_q.size() == 0) && !o_valid;
        end
        chk("drain_done", 32'(done), 32'd1);
        @(posedge i_clk);
        #1;
    endtask

    // Single op on an empty pipe with i_ready=1: o_valid must rise exactly 2 cycles later.
    task automatic directed(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                            input logic [7:0] er, input logic [4:0] ef);
        send(a, b, op);
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("latency_c1_valid", 32'(o_valid), 32'd0);
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        chk("latency_c2_valid", 32'(o_valid), 32'd1);
        chk("directed_result", 32'({o_result, o_zero, o_negative, o_carry, o_overflow, o_err}),
            32'({er, ef}));
        @(posedge i_clk);
        #1;
    endtask

    logic [5:0] op_tab [11];
    logic [7:0] ra, rb;
    logic [5:0] rop;

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        op_tab = '{ADD, SUB, AND_, OR_, XOR_, NOR_, SRL, SRA, SLL, SLT, SLTU};

        // Reset state, then the first op on the first edge after release.
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_o_valid", 32'(o_valid), 32'd0);
        chk("reset_o_ready", 32'(o_ready), 32'd1);
        chk("reset_outputs", 32'({o_result, o_zero, o_negative, o_carry, o_overflow, o_err}), 32'd0);
        i_reset = 1'b0;

        //          a      b      op     result  {z,n,c,v,err}
        directed(8'hFF, 8'h01, ADD,  8'h00, 5'b10100);
        directed(8'h80, 8'h01, SUB,  8'h7F, 5'b00010);
        directed(8'h01, 8'h02, SUB,  8'hFF, 5'b01100);
        directed(8'h80, 8'h03, SRA,  8'hF0, 5'b01000);
        directed(8'h80, 8'h09, SRL,  8'h00, 5'b10000);
        directed(8'h01, 8'h07, SLL,  8'h80, 5'b01000);
        directed(8'hFF, 8'h01, SLT,  8'h01, 5'b00000);
        directed(8'hFF, 8'h01, SLTU, 8'h00, 5'b10000);
        directed(8'h0F, 8'hF0, NOR_, 8'h00, 5'b10000);
        directed(8'hF0, 8'h3C, AND_, 8'h30, 5'b00000);
        directed(8'h40, 8'h40, ADD,  8'h80, 5'b01010);
        directed(8'h12, 8'h34, 6'b111111, 8'h00, 5'b10001);
        drain();

        // Backpressure: two ops fill the pipe, the third is refused until i_ready rises.
        rdy_force = 1'b0;
        send(8'h01, 8'h01, ADD);
        send(8'h02, 8'h02, ADD);
        i_data_a = 8'h03;
        i_data_b = 8'h03;
        i_op     = ADD;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("bp_o_ready_low", 32'(o_ready), 32'd0);
            chk("bp_hold_result", 32'(o_result), 32'h02);
            @(posedge i_clk);
            #1;
        end
        rdy_force = 1'b1;
        @(negedge i_clk);
        chk("bp_accept_third", 32'(o_ready), 32'd1);
        chk("bp_out0", 32'({o_valid, o_result}), 32'h102);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("bp_out1", 32'({o_valid, o_result}), 32'h104);
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        chk("bp_out2", 32'({o_valid, o_result}), 32'h106);
        @(posedge i_clk);
        #1;
        drain();

        // Reset with both stages full: everything in flight is discarded.
        rdy_force = 1'b0;
        send(8'h05, 8'h05, ADD);
        send(8'h06, 8'h06, ADD);
        i_data_a = 8'h07;
        i_data_b = 8'h07;
        #2;
        i_reset = 1'b1;
        #1;
        sb_q.delete();
        i_valid = 1'b0;
        chk("rst_mid_o_valid", 32'(o_valid), 32'd0);
        chk("rst_mid_o_ready", 32'(o_ready), 32'd1);
        chk("rst_mid_outputs", 32'({o_result, o_zero, o_negative, o_carry, o_overflow, o_err}), 32'd0);
        @(posedge i_clk);
        #1;
        i_reset   = 1'b0;
        rdy_force = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk("rst_no_stale", 32'(o_valid), 32'd0);
        end
        @(posedge i_clk);
        #1;
        directed(8'h10, 8'h20, OR_, 8'h30, 5'b00000);

        // Random traffic with random downstream stalls.
        rand_mode = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                i_valid = 1'b0;
                @(posedge i_clk);
                #1;
            end
            rop = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 10)];
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12)) : 8'($urandom);
            send(ra, rb, rop);
        end
        i_valid   = 1'b0;
        rand_mode = 1'b0;
        rdy_force = 1'b1;
        drain();
        chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, giving the operand and result width in bits (legal range 4..32).
REQ-002 The block SHALL have parameter NB_OP, default 6, giving the opcode width in bits (fixed encoding, see REQ-014).
REQ-003 The block SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_valid, input, 1 bit: the upstream operation on i_data_a/i_data_b/i_op is valid.
REQ-006 The block SHALL have port o_ready, output, 1 bit: the block accepts the upstream operation this cycle.
REQ-007 The block SHALL have ports i_data_a and i_data_b, input, NB_DATA bits each: operands A and B.
REQ-008 The block SHALL have port i_op, input, NB_OP bits: operation code.
REQ-009 The block SHALL have port o_valid, output, 1 bit: the result and flags are valid.
REQ-010 The block SHALL have port i_ready, input, 1 bit: downstream consumes the result.
REQ-011 The block SHALL have port o_result, output, NB_DATA bits: the result.
REQ-012 The block SHALL have ports o_zero, o_negative, o_carry, o_overflow and o_err, output, 1 bit each: the flags.

Function
REQ-013 The block SHALL be a 2-stage pipeline.
- S1 registers the operands and opcode.
- S2 computes from the S1 registers and registers the result and flags into the output stage.
REQ-014 The block SHALL implement these opcodes:
- ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111.
- SRL 000010, SRA 000011, SLL 000000.
- SLT 101010 (signed), SLTU 101011 (unsigned).
REQ-015 An upstream transfer SHALL occur when i_valid && o_ready; a downstream transfer SHALL occur when o_valid && i_ready.
REQ-016 Ready SHALL be computed as follows, with no combinational path from i_valid to o_ready:
- s2_ready = !o_valid || i_ready.
- o_ready = !s1_valid || s2_ready.
REQ-017 S1 SHALL pass its contents to the output stage when s1_valid && s2_ready; s1_valid SHALL then clear unless a new upstream transfer occurs in the same cycle.
REQ-018 Latency SHALL be exactly 2 cycles from upstream transfer to o_valid when i_ready is held at 1.
REQ-019 Throughput SHALL be 1 operation per cycle, and results SHALL be delivered in order.
REQ-020 While o_valid && !i_ready, o_result and all flags SHALL be held stable.
REQ-021 With S1 and the output stage both full and i_ready=0, o_ready SHALL be 0.
REQ-022 A simultaneous upstream and downstream transfer with both stages full SHALL neither lose nor duplicate any operation.
REQ-023 ADD/SUB SHALL use an NB_DATA+1-bit internal result.
- ADD: o_carry = carry-out.
- SUB: o_carry = borrow (A < B unsigned).
- o_overflow = signed overflow of the NB_DATA-bit result.
REQ-024 o_carry and o_overflow SHALL be 0 for every opcode other than ADD/SUB.
REQ-025 Shift amount SHALL be the full unsigned value of B; for amounts >= NB_DATA:
- SRL and SLL give 0.
- SRA gives all bits equal to A[NB_DATA-1].
REQ-026 SLT/SLTU SHALL give result 1 if A < B (signed/unsigned respectively), else 0, zero-extended to NB_DATA bits.
REQ-027 o_zero SHALL equal (o_result == 0); o_negative SHALL equal o_result[NB_DATA-1].
REQ-028 An undefined opcode SHALL give o_result=0, o_err=1 and o_zero=1, with other flags 0; o_err SHALL be 0 for defined opcodes.

Reset
REQ-029 While i_reset=1, asynchronously:
- s1_valid=0 and o_valid=0.
- o_result=0 and all flags 0.
- o_ready=1.
REQ-030 Operations in flight when reset asserts SHALL be discarded and never appear on the output.
REQ-031 The first upstream transfer SHALL be possible on the first rising edge after i_reset deasserts.

Verification (NB_DATA=8, i_ready=1 unless stated)
REQ-032 ADD A=0xFF, B=0x01 -> 2 cycles later o_valid=1, result 0x00, zero=1, carry=1, overflow=0.
REQ-033 SUB A=0x80, B=0x01 -> result 0x7F, overflow=1, carry=0, negative=0; SUB 0x01-0x02 -> 0xFF, carry=1, negative=1.
REQ-034 Shifts:
- SRA A=0x80, B=3 -> 0xF0.
- SRL A=0x80, B=9 -> 0x00, zero=1.
- SLL A=0x01, B=7 -> 0x80.
- SLT A=0xFF, B=0x01 -> 0x01; SLTU same operands -> 0x00.
REQ-035 Backpressure: i_ready=0, i_valid=1 with ops ADD 1+1, ADD 2+2, ADD 3+3 back-to-back ->
- the first two are accepted and o_ready=0 on the third.
- o_result holds 0x02.
- After i_ready=1: 0x02, 0x04, 0x06 in consecutive cycles, no gaps, no loss.
REQ-036 Illegal op 111111 -> result 0x00, err=1, zero=1.
REQ-037 i_reset pulsed with both stages full -> o_valid=0 immediately, no stale result after release, o_ready=1.
